mant_add_stage: RTL and testbench
=================================

MANT_ADD_STAGE -- requirements
Module: mant_add_stage

Interface
REQ-001 Parameter MANT_W, default 24, is the width of the mantissa field of float_point_num from float_types_pkg and SHALL equal $bits(float_point_num.mant).
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 arstn_i  input  1  reset, asynchronous, active-low.
REQ-004 a_i  input  float_point_num  operand A after alignment (exp equal to b_i.exp).
REQ-005 b_i  input  float_point_num  operand B after alignment.
REQ-006 sub_i  input  1  1 = compute A-B (B sign inverted), 0 = A+B.
REQ-007 valid_i  input  1  a_i/b_i/sub_i valid this cycle.
REQ-008 ready_o  output  1  stage can accept input this cycle.
REQ-009 sign_o  output  1  result sign.
REQ-010 exp_o  output  8  result exponent, pre-normalisation.
REQ-011 mant_o  output  MANT_W+1  result magnitude, MSB is carry-out.
REQ-012 zero_o  output  1  result magnitude is exactly zero.
REQ-013 valid_o  output  1  outputs hold a valid result.
REQ-014 ready_i  input  1  downstream (normalise stage) accepts result this cycle.

Function
REQ-015 Effective sign of B SHALL be b_i.sign XOR sub_i.
REQ-016 Equal effective signs: mant_o = zero-extended a_i.mant + b_i.mant; sign_o = a_i.sign.
REQ-017 Different effective signs, a_i.mant > b_i.mant: mant_o = a_i.mant - b_i.mant; sign_o = a_i.sign.
REQ-018 Different effective signs, b_i.mant > a_i.mant: mant_o = b_i.mant - a_i.mant; sign_o = effective B sign.
REQ-019 Different effective signs, mantissas equal: mant_o = 0, sign_o = 0 (+0), zero_o = 1.
REQ-020 zero_o SHALL be 1 whenever the registered mant_o is all zeros, including 0+0 with equal signs, where sign_o keeps a_i.sign.
REQ-021 exp_o SHALL equal a_i.exp; b_i.exp is not checked.
REQ-022 Subtraction results SHALL never set the mant_o MSB; only addition can produce a carry.
REQ-023 The stage is a single register stage: latency exactly 1 cycle from accepted input to valid_o.
REQ-024 ready_o = !valid_o || ready_i (combinational, no dependence on valid_i).
REQ-025 Input accepted when valid_i && ready_o; result registers load on that edge and valid_o is 1 next cycle.
REQ-026 valid_o && !ready_i (stall): all outputs SHALL hold unchanged; ready_o = 0; no input accepted.
REQ-027 Output consumed (valid_o && ready_i) with no new input accepted: valid_o clears next cycle; data registers may hold stale values.
REQ-028 Simultaneous consume and accept: valid_o stays 1, data replaced by new result, no bubble; full throughput of 1 result/cycle.
REQ-029 Data registers SHALL NOT change when no input is accepted.
REQ-030 Inputs with valid_i = 0 SHALL be ignored regardless of content.

Reset
REQ-031 arstn_i low SHALL immediately force valid_o = 0, sign_o = 0, exp_o = 0, mant_o = 0, zero_o = 1, independent of clk_i.
REQ-032 Reset asserted mid-stall SHALL discard the held result; no result emitted after release.
REQ-033 First input is accepted on the first rising edge with arstn_i high and valid_i high; ready_o = 1 throughout reset.

Verification
REQ-034 Carry: A=(0,0x80,0x800000), B=(0,0x80,0x800000), sub_i=0 -> next cycle mant_o=0x1000000, exp_o=0x80, sign_o=0, zero_o=0, valid_o=1.
REQ-035 Cancellation: A=(0,0x85,0xC00000), B=(0,0x85,0xC00000), sub_i=1 -> mant_o=0, sign_o=0, zero_o=1.
REQ-036 Sign of larger: A=(0,0x7F,0x900000), B=(1,0x7F,0xA00000), sub_i=0 -> mant_o=0x100000, sign_o=1; same with sub_i=1 -> mant_o=0x1300000, sign_o=0.
REQ-037 Stall: result valid, ready_i=0 for 3 cycles while valid_i=1 with new data -> outputs constant, ready_o=0; ready_i=1 -> new data loaded next cycle, valid_o stays 1.
REQ-038 Back-to-back: valid_i=1, ready_i=1 for 8 cycles with distinct operands -> 8 results in order, one per cycle, each 1 cycle after its input.
REQ-039 Reset mid-operation: arstn_i pulsed low while valid_o=1 stalled -> valid_o=0 asynchronously, mant_o=0, zero_o=1; no result after release until new input.

Source files
------------

// File: rtl/mant_add_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : mant_add_stage_if
// Description : Handshake and data bundle for the mantissa add stage.
//               Operands travel as packed {sign, exp[7:0], mant[MANT_W-1:0]}
//               words that match float_types_pkg::float_point_num.
//               slave  - the add stage (consumes operands, produces result)
//               master - the upstream/downstream environment
// Revision    : 1.0 - initial release
// ============================================================================
interface mant_add_stage_if #(
  parameter int MANT_W = 24
);
  logic [MANT_W+8:0] a_i;      // operand A, already aligned
  logic [MANT_W+8:0] b_i;      // operand B, already aligned
  logic              sub_i;    // 1 = A-B, 0 = A+B
  logic              valid_i;  // operands valid this cycle
  logic              ready_o;  // stage can accept operands
  logic              sign_o;   // result sign
  logic [7:0]        exp_o;    // result exponent, pre-normalisation
  logic [MANT_W:0]   mant_o;   // result magnitude, MSB is carry-out
  logic              zero_o;   // result magnitude is exactly zero
  logic              valid_o;  // result valid
  logic              ready_i;  // downstream accepts result

  modport slave (
    input  a_i, b_i, sub_i, valid_i, ready_i,
    output ready_o, sign_o, exp_o, mant_o, zero_o, valid_o
  );

  modport master (
    output a_i, b_i, sub_i, valid_i, ready_i,
    input  ready_o, sign_o, exp_o, mant_o, zero_o, valid_o
  );
endinterface
`default_nettype wire

// File: rtl/mant_add_stage.sv
`default_nettype none
// ============================================================================
// Package     : float_types_pkg
// Description : Shared floating-point field layout.
// Revision    : 1.0 - initial release
// ============================================================================
package float_types_pkg;
  localparam int FP_MANT_W = 24;

  typedef struct packed {
    logic                 sign;
    logic [7:0]           exp;
    logic [FP_MANT_W-1:0] mant;
  } float_point_num;
endpackage

// ============================================================================
// Module      : mant_add_stage
// Description : Single register stage adding/subtracting two aligned
//               mantissas. Produces sign-magnitude result with carry-out,
//               pre-normalisation exponent and zero flag, behind a
//               valid/ready handshake with full 1 result/cycle throughput.
// Ports       : clk_i   - clock, rising edge
//               arstn_i - asynchronous active-low reset
//               bus     - mant_add_stage_if.slave (operands in, result out)
// Revision    : 1.0 - initial release
// ============================================================================
module mant_add_stage
  import float_types_pkg::*;
#(
  // Must match the mantissa width of float_point_num.
  parameter int MANT_W = FP_MANT_W
) (
  input  wire             clk_i,
  input  wire             arstn_i,
  mant_add_stage_if.slave bus
);

  float_point_num  w_a;
  float_point_num  w_b;
  logic            w_b_sign_eff;
  logic            w_accept;
  logic            w_sign;
  logic [MANT_W:0] w_mant;

  logic            r_valid;
  logic            r_sign;
  logic [7:0]      r_exp;
  logic [MANT_W:0] r_mant;
  logic            r_zero;

  assign w_a = bus.a_i;
  assign w_b = bus.b_i;

  // Subtraction is folded into B's sign so one magnitude path covers both ops.
  assign w_b_sign_eff = w_b.sign ^ bus.sub_i;

  // Sign-magnitude add: when effective signs differ, the smaller magnitude
  // is always subtracted from the larger, so the carry bit stays clear.
  always_comb begin
    w_sign = w_a.sign;
    w_mant = '0;
    if (w_a.sign == w_b_sign_eff) begin
      w_mant = {1'b0, w_a.mant} + {1'b0, w_b.mant};
      w_sign = w_a.sign;
    end else if (w_a.mant > w_b.mant) begin
      w_mant = {1'b0, w_a.mant} - {1'b0, w_b.mant};
      w_sign = w_a.sign;
    end else if (w_b.mant > w_a.mant) begin
      w_mant = {1'b0, w_b.mant} - {1'b0, w_a.mant};
      w_sign = w_b_sign_eff;
    end else begin
      // Exact cancellation yields +0.
      w_mant = '0;
      w_sign = 1'b0;
    end
  end

  // Ready never looks at valid_i, avoiding a combinational valid->ready path.
  assign bus.ready_o = !r_valid || bus.ready_i;
  assign w_accept    = bus.valid_i && bus.ready_o;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_valid <= 1'b0;
      r_sign  <= 1'b0;
      r_exp   <= 8'h00;
      r_mant  <= '0;
      r_zero  <= 1'b1;
    end else begin
      // When ready_o is high the slot is free or being drained this cycle,
      // so valid simply follows the incoming valid.
      if (bus.ready_o) begin
        r_valid <= bus.valid_i;
      end
      if (w_accept) begin
        r_sign <= w_sign;
        r_exp  <= w_a.exp;
        r_mant <= w_mant;
        r_zero <= (w_mant == '0);
      end
    end
  end

  assign bus.valid_o = r_valid;
  assign bus.sign_o  = r_sign;
  assign bus.exp_o   = r_exp;
  assign bus.mant_o  = r_mant;
  assign bus.zero_o  = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_mant_add_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mant_add_stage
// Description : Self-checking bench for mant_add_stage: table of directed
//               vectors plus stall, back-to-back and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mant_add_stage;

  logic clk_i   = 1'b0;
  logic arstn_i = 1'b1;
  int   n_vec   = 0;
  int   n_bad   = 0;

  always #5 clk_i = ~clk_i;

  mant_add_stage_if #(.MANT_W(24)) bus ();

  mant_add_stage #(.MANT_W(24)) dut (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .bus     (bus.slave)
  );

  typedef struct {
    logic        sa;
    logic [7:0]  ea;
    logic [23:0] ma;
    logic        sb;
    logic [7:0]  eb;
    logic [23:0] mb;
    logic        sub;
    logic        es;
    logic [7:0]  ee;
    logic [24:0] em;
    logic        ez;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  task automatic chk_out(input string name, input logic v, input logic s,
                         input logic [7:0] e, input logic [24:0] m, input logic z);
    chk({name, ".valid"}, 32'(bus.valid_o), 32'(v));
    chk({name, ".sign"},  32'(bus.sign_o),  32'(s));
    chk({name, ".exp"},   32'(bus.exp_o),   32'(e));
    chk({name, ".mant"},  32'(bus.mant_o),  32'(m));
    chk({name, ".zero"},  32'(bus.zero_o),  32'(z));
  endtask

  task automatic drive(input logic v, input logic sa, input logic [7:0] ea,
                       input logic [23:0] ma, input logic sb, input logic [7:0] eb,
                       input logic [23:0] mb, input logic sub);
    bus.valid_i = v;
    bus.a_i     = {sa, ea, ma};
    bus.b_i     = {sb, eb, mb};
    bus.sub_i   = sub;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [23:0] ma, mb;

    //            sa  ea     ma          sb  eb     mb          sub  es  ee     em           ez
    vt[0] = '{1'b0, 8'h80, 24'h800000, 1'b0, 8'h80, 24'h800000, 1'b0, 1'b0, 8'h80, 25'h1000000, 1'b0};
    vt[1] = '{1'b0, 8'h85, 24'hC00000, 1'b0, 8'h85, 24'hC00000, 1'b1, 1'b0, 8'h85, 25'h0000000, 1'b1};
    vt[2] = '{1'b0, 8'h7F, 24'h900000, 1'b1, 8'h7F, 24'hA00000, 1'b0, 1'b1, 8'h7F, 25'h0100000, 1'b0};
    vt[3] = '{1'b0, 8'h7F, 24'h900000, 1'b1, 8'h7F, 24'hA00000, 1'b1, 1'b0, 8'h7F, 25'h1300000, 1'b0};
    vt[4] = '{1'b1, 8'h10, 24'h000000, 1'b1, 8'h10, 24'h000000, 1'b0, 1'b1, 8'h10, 25'h0000000, 1'b1};
    vt[5] = '{1'b1, 8'h90, 24'hF00000, 1'b0, 8'h90, 24'h100000, 1'b0, 1'b1, 8'h90, 25'h0E00000, 1'b0};
    vt[6] = '{1'b0, 8'hFE, 24'hFFFFFF, 1'b0, 8'hFE, 24'hFFFFFF, 1'b0, 1'b0, 8'hFE, 25'h1FFFFFE, 1'b0};
    vt[7] = '{1'b0, 8'h20, 24'h400000, 1'b0, 8'h55, 24'h300000, 1'b1, 1'b0, 8'h20, 25'h0100000, 1'b0};
    vt[8] = '{1'b1, 8'h01, 24'h000001, 1'b1, 8'h01, 24'h000002, 1'b1, 1'b0, 8'h01, 25'h0000001, 1'b0};
    vt[9] = '{1'b0, 8'hFF, 24'hFFFFFF, 1'b1, 8'hFF, 24'h000000, 1'b0, 1'b0, 8'hFF, 25'h0FFFFFF, 1'b0};

    bus.ready_i = 1'b1;
    drive(1'b1, 1'b1, 8'hAA, 24'h123456, 1'b0, 8'hAA, 24'h654321, 1'b0);

    // Asynchronous reset, before any clock edge.
    #1 arstn_i = 1'b0;
    #2;
    chk_out("rst_async", 1'b0, 1'b0, 8'h00, 25'h0, 1'b1);
    chk("rst_ready", 32'(bus.ready_o), 32'd1);
    bus.ready_i = 1'b0;
    #1;
    chk("rst_ready_stalled", 32'(bus.ready_o), 32'd1);
    step();
    step();
    chk_out("rst_held", 1'b0, 1'b0, 8'h00, 25'h0, 1'b1);
    @(negedge clk_i);
    arstn_i = 1'b1;
    bus.ready_i = 1'b1;

    // Table-driven vectors, back-to-back.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, vt[i].sa, vt[i].ea, vt[i].ma, vt[i].sb, vt[i].eb, vt[i].mb, vt[i].sub);
      step();
      chk_out($sformatf("vec%0d", i), 1'b1, vt[i].es, vt[i].ee, vt[i].em, vt[i].ez);
      @(negedge clk_i);
    end
    drive(1'b0, 1'b0, 8'h00, 24'h0, 1'b0, 8'h00, 24'h0, 1'b0);
    step();
    chk("drain.valid", 32'(bus.valid_o), 32'd0);

    // Stall: result held while new data waits on valid_i.
    @(negedge clk_i);
    bus.ready_i = 1'b0;
    drive(1'b1, 1'b0, 8'h40, 24'h100000, 1'b0, 8'h40, 24'h200000, 1'b0);
    step();
    chk_out("stall_load", 1'b1, 1'b0, 8'h40, 25'h0300000, 1'b0);
    @(negedge clk_i);
    drive(1'b1, 1'b0, 8'h41, 24'h500000, 1'b0, 8'h41, 24'h100000, 1'b1);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("stall%0d.ready", c), 32'(bus.ready_o), 32'd0);
      step();
      chk_out($sformatf("stall%0d", c), 1'b1, 1'b0, 8'h40, 25'h0300000, 1'b0);
      @(negedge clk_i);
    end
    bus.ready_i = 1'b1;
    #1;
    chk("unstall.ready", 32'(bus.ready_o), 32'd1);
    step();
    chk_out("unstall", 1'b1, 1'b0, 8'h41, 25'h0400000, 1'b0);
    @(negedge clk_i);
    drive(1'b0, 1'b1, 8'hEE, 24'hABCDEF, 1'b1, 8'hEE, 24'h111111, 1'b0);
    step();
    chk("consume.valid", 32'(bus.valid_o), 32'd0);
    chk("idle_hold.mant", 32'(bus.mant_o), 32'h0400000);

    // Back-to-back streaming, one result per cycle in order.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      ma = 24'(32'h100000 * (i + 1));
      mb = 24'(32'h000100 * (i + 3));
      drive(1'b1, 1'b0, 8'(8'h10 + i), ma, 1'b0, 8'(8'h10 + i), mb, 1'b0);
      step();
      chk_out($sformatf("b2b%0d", i), 1'b1, 1'b0, 8'(8'h10 + i),
              {1'b0, ma} + {1'b0, mb}, 1'b0);
    end
    @(negedge clk_i);
    drive(1'b0, 1'b0, 8'h00, 24'h0, 1'b0, 8'h00, 24'h0, 1'b0);
    step();
    chk("b2b_end.valid", 32'(bus.valid_o), 32'd0);

    // Reset during a stall discards the held result.
    @(negedge clk_i);
    bus.ready_i = 1'b0;
    drive(1'b1, 1'b0, 8'h33, 24'h700000, 1'b0, 8'h33, 24'h000001, 1'b0);
    step();
    chk_out("prerst", 1'b1, 1'b0, 8'h33, 25'h0700001, 1'b0);
    #2 arstn_i = 1'b0;
    #1;
    chk_out("midrst", 1'b0, 1'b0, 8'h00, 25'h0, 1'b1);
    @(negedge clk_i);
    arstn_i = 1'b1;
    drive(1'b0, 1'b1, 8'h77, 24'hFFFFFF, 1'b0, 8'h77, 24'h000001, 1'b1);
    step();
    step();
    chk_out("postrst_idle", 1'b0, 1'b0, 8'h00, 25'h0, 1'b1);
    @(negedge clk_i);
    drive(1'b1, 1'b0, 8'h05, 24'h000003, 1'b1, 8'h05, 24'h000001, 1'b0);
    step();
    chk_out("postrst_new", 1'b1, 1'b0, 8'h05, 25'h0000002, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
